// File: rtl/midi_tx_if.sv
// MIDI OUT message handshake: one complete message (status + up to two data
// bytes) per valid/ready transfer.
interface midi_tx_if;
    logic       msg_valid;
    logic       msg_ready;
    logic [7:0] msg_status;
    logic [6:0] msg_data1;
    logic [6:0] msg_data2;

    modport master (
        output msg_valid,
        output msg_status,
        output msg_data1,
        output msg_data2,
        input  msg_ready
    );

    modport slave (
        input  msg_valid,
        input  msg_status,
        input  msg_data1,
        input  msg_data2,
        output msg_ready
    );
endinterface

// File: rtl/midi_tx.sv
// MIDI OUT serializer: 8N1, LSB first, CLKS_PER_BIT clocks per bit.
// Decodes the byte count from the status byte, optionally drops a repeated
// channel status byte (running status), and shifts bytes out back-to-back.
module midi_tx #(
    parameter int CLKS_PER_BIT   = 800,
    parameter bit RUNNING_STATUS = 1'b1
) (
    input  logic       clk25,
    input  logic       rst_n,
    midi_tx_if.slave   msg,
    output logic       tx,
    output logic       busy,
    output logic       drop
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    // The byte-select (LOAD) step takes no cycle of its own: it happens on the
    // accepting edge and on the final STOP edge, so the FSM goes straight to START.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [7:0]    sh;        // byte on the wire, shifted right per bit
    logic [7:0]    nxt1;      // next byte queued behind sh
    logic [7:0]    nxt2;      // byte after nxt1
    logic [1:0]    rem;       // bytes still to send after the current one
    logic [7:0]    rs;        // running-status register
    logic          rs_vld;    // rs holds a valid channel status
    logic          ready;

    logic [7:0] st;
    logic       is_chan;
    logic       is_sys;
    logic       two_data;
    logic       skip_st;
    logic [1:0] nb;
    logic [7:0] b0, b1, b2;
    logic       baud_last;

    assign st        = msg.msg_status;
    assign msg.msg_ready = ready;
    assign busy      = ~ready;
    assign baud_last = (baud == BAUD_LAST);

    // Decode the offered status byte and lay out the bytes to transmit in order.
    always_comb begin
        is_chan  = st[7] && (st[6:4] != 3'b111);          // 0x80-0xEF
        is_sys   = (st[7:3] == 5'b11110);                 // 0xF0-0xF7
        two_data = is_chan && (st[6:5] != 2'b10);         // not 0xC0-0xDF
        skip_st  = RUNNING_STATUS && is_chan && rs_vld && (rs == st);
        nb = 2'd1;
        if (is_chan)
            nb = two_data ? 2'd3 : 2'd2;
        if (skip_st)
            nb = nb - 2'd1;
        b0 = skip_st ? {1'b0, msg.msg_data1} : st;
        b1 = skip_st ? {1'b0, msg.msg_data2} : {1'b0, msg.msg_data1};
        b2 = {1'b0, msg.msg_data2};
    end

    // Message FSM, baud/bit counters and line driver.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= 3'd0;
            sh      <= 8'h00;
            nxt1    <= 8'h00;
            nxt2    <= 8'h00;
            rem     <= 2'd0;
            rs      <= 8'h00;
            rs_vld  <= 1'b0;
            ready   <= 1'b1;
            tx      <= 1'b1;
            drop    <= 1'b0;
        end else begin
            drop <= 1'b0;
            case (state)
                IDLE: begin
                    if (msg.msg_valid) begin
                        if (!st[7]) begin
                            // Not a status byte: complete the handshake, send nothing.
                            drop <= 1'b1;
                        end else begin
                            sh      <= b0;
                            nxt1    <= b1;
                            nxt2    <= b2;
                            rem     <= nb - 2'd1;
                            if (is_chan) begin
                                rs     <= st;
                                rs_vld <= 1'b1;
                            end else if (is_sys) begin
                                rs_vld <= 1'b0;
                            end
                            baud    <= '0;
                            bit_idx <= 3'd0;
                            tx      <= 1'b0;
                            ready   <= 1'b0;
                            state   <= START;
                        end
                    end
                end
                START: begin
                    if (baud_last) begin
                        baud    <= '0;
                        bit_idx <= 3'd0;
                        tx      <= sh[0];
                        sh      <= {1'b0, sh[7:1]};
                        state   <= DATA;
                    end else begin
                        baud <= baud + CW'(1);
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= sh[0];
                            sh      <= {1'b0, sh[7:1]};
                        end
                    end else begin
                        baud <= baud + CW'(1);
                    end
                end
                STOP: begin
                    if (baud_last) begin
                        baud <= '0;
                        if (rem != 2'd0) begin
                            // Next byte follows immediately, no idle gap.
                            sh      <= nxt1;
                            nxt1    <= nxt2;
                            rem     <= rem - 2'd1;
                            bit_idx <= 3'd0;
                            tx      <= 1'b0;
                            state   <= START;
                        end else begin
                            ready <= 1'b1;
                            state <= IDLE;
                        end
                    end else begin
                        baud <= baud + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/midi_tx.md
Name: midi_tx

Overview:
- MIDI OUT serializer: the transmit end of the 31250 baud 8N1 MIDI link that midi_if receives.
- Accepts one complete MIDI message per valid/ready handshake.
- Works out the byte count from the status byte, applies optional running-status compression, and shifts the bytes out LSB-first on tx.
- Runs on the 25 MHz system clock. Drives an external MIDI OUT port, or feeds midi_if directly for loopback testing.

Parameters:
- CLKS_PER_BIT, 800, clk25 cycles per bit (25 MHz / 31250 baud); must be ≥ 2.
- RUNNING_STATUS, 1, when 1, omit a repeated channel status byte; when 0, always send the status byte.

Ports:
- clk25  input  1  system clock, 25 MHz.
- rst_n  input  1  asynchronous active-low reset.
- msg_valid  input  1  message present on msg_* inputs.
- msg_ready  output  1  block can accept a message.
- msg_status  input  8  status byte; bit7 must be 1.
- msg_data1  input  7  first data byte.
- msg_data2  input  7  second data byte.
- tx  output  1  serial MIDI line; idle high.
- busy  output  1  frame in progress; equals ~msg_ready.
- drop  output  1  one-cycle pulse when a message is rejected.

Behaviour:
- Reset (asynchronous, immediate):
  - tx=1, msg_ready=1, busy=0, drop=0.
  - Running-status register cleared to "none".
  - All counters zeroed.
  - Reset mid-frame truncates the byte: tx goes high at once and the message is lost.
- Handshake:
  - A message is accepted on the clk25 edge where msg_valid && msg_ready. Inputs are captured into internal registers.
  - msg_ready deasserts the next cycle.
  - msg_ready reasserts in the cycle after the last stop bit completes.
  - Inputs are don't-care while msg_ready=0.
- Rejection:
  - If msg_status[7]=0, the handshake still completes but nothing is sent. drop pulses 1 the cycle after acceptance, and msg_ready stays 1.
- Byte count, decoded from the captured status byte:
  - 0x80–0xBF and 0xE0–0xEF: 3 bytes.
  - 0xC0–0xDF: 2 bytes.
  - 0xF0–0xF7: 1 byte; clears the running-status register.
  - 0xF8–0xFF (realtime): 1 byte; running-status register unchanged.
- Running status:
  - Applies only when RUNNING_STATUS=1, the status is in 0x80–0xEF, and it equals the running-status register. The status byte is then skipped and only the data bytes are sent.
  - Any transmitted status in 0x80–0xEF loads the running-status register.
- FSM states: IDLE → LOAD → START → DATA → STOP → (LOAD if bytes remain, else IDLE).
  - LOAD: selects the next byte (status, data1, data2) into the shift register. Zero-time: the combinationally loaded byte is sent from the START entered in the same cycle as the handshake edge.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
  - Bytes within a message are back-to-back with no idle gap.
- Timing:
  - The start bit's first cycle is the cycle after the accepting edge.
  - Frame = 10×CLKS_PER_BIT = 8000 cycles.
  - A message of n transmitted bytes holds msg_ready low for exactly n×8000 cycles.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and wraps.
  - Bit index counts 0..7.
  - Both reset at each START entry, so no drift carries between bytes.
- Data bytes are sent as {1'b0, msg_dataN}.
- msg_valid asserted continuously: a new message is accepted in the first cycle msg_ready=1, with no mandatory idle between messages.

Test Plan:
1. Full note-on. After reset, send 0x90,0x3C,0x64 → tx carries bytes 0x90, 0x3C, 0x64 (8N1, LSB first). Start bit begins 1 cycle after the handshake, each bit is 800 cycles, and msg_ready is low for exactly 24000 cycles. midi_if loopback decodes the same 3 bytes.
2. Running status on. Then send 0x90,0x40,0x7F with RUNNING_STATUS=1 → only 0x40, 0x7F are sent; msg_ready is low 16000 cycles. The same stimulus with RUNNING_STATUS=0 → 3 bytes, 24000 cycles.
3. Program change and realtime. Send 0xC5,0x0A → bytes 0xC5, 0x0A (16000 cycles). Then 0xF8 → single byte 0xF8 (8000 cycles). Then 0xC5,0x0B → only 0x0B is sent, because realtime keeps running status. Then 0xF0 → 0xF0 is sent; a following 0xC5,0x0C sends 0xC5, 0x0C.
4. Rejection. Send status 0x3C → no tx activity, drop=1 for exactly one cycle, msg_ready remains 1.
5. Reset mid-frame. Pull rst_n low during bit 4 of the status byte of 0x90,0x3C,0x64 → tx=1 asynchronously and msg_ready=1. After release, resending 0x90,0x3C,0x64 sends all 3 bytes, because running status was cleared.
6. Back-to-back. Hold msg_valid high across two 0x80 note-offs → the second handshake occurs the cycle msg_ready rises, and the tx start bit follows on the next cycle with no extra idle stop time.
